// File: rtl/periph_bus_master_pkg.sv
// Shared definitions for the peripheral bus initiator: bus widths, slot
// indices, FSM state encoding and the latched-request record.
package periph_bus_master_pkg;

   localparam int PERIPH_IDX_W = 3;
   localparam int REG_ADDR_W   = 5;
   localparam int REQ_ADDR_W   = PERIPH_IDX_W + REG_ADDR_W;
   localparam int BUS_WDATA_W  = 16;
   localparam int BUS_RDATA_W  = 32;
   localparam int WAIT_W       = 4;
   localparam int MAX_PERIPH   = 8;

   localparam int PERIPH_MULT  = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic                    we;
      logic [PERIPH_IDX_W-1:0] idx;
   } req_t;

   function automatic logic [PERIPH_IDX_W-1:0] periphIndex(input logic [REQ_ADDR_W-1:0] reqAddr);
      return reqAddr[REQ_ADDR_W-1:REG_ADDR_W];
   endfunction

   function automatic logic [REG_ADDR_W-1:0] regAddress(input logic [REQ_ADDR_W-1:0] reqAddr);
      return reqAddr[REG_ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Core request/response port plus the peripheral bus, bundled so the
// initiator sees one master view and the core/peripherals one slave view.
interface periph_bus_master_if
   import periph_bus_master_pkg::*;
#(
   parameter int NUM_PERIPH = 4
) ();

   logic                            req_valid;
   logic                            req_ready;
   logic                            req_we;
   logic [REQ_ADDR_W-1:0]           req_addr;
   logic [BUS_WDATA_W-1:0]          req_wdata;

   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [BUS_RDATA_W-1:0]          rsp_rdata;
   logic                            rsp_err;

   logic [NUM_PERIPH-1:0]           cs;
   logic [REG_ADDR_W-1:0]           addr;
   logic                            rd;
   logic                            wr;
   logic [BUS_WDATA_W-1:0]          d_in;
   logic [BUS_RDATA_W*NUM_PERIPH-1:0] d_out_bus;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, d_out_bus,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, cs, addr, rd, wr, d_in
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, d_out_bus,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, cs, addr, rd, wr, d_in
   );

endinterface

// File: rtl/periph_bus_master_cs_decode.sv
// Combinational peripheral-index decoder: one-hot chip select plus a flag
// for indices that have no slot behind them.
module periph_bus_master_cs_decode
   import periph_bus_master_pkg::*;
#(
   parameter int NUM_PERIPH = 4
) (
   input  logic [PERIPH_IDX_W-1:0] index,
   output logic [NUM_PERIPH-1:0]   csOneHot,
   output logic                    outOfRange
);

   always_comb begin
      csOneHot   = '0;
      outOfRange = (int'(index) >= NUM_PERIPH);
      for (int i = 0; i < NUM_PERIPH; i++) begin
         if (index == PERIPH_IDX_W'(i)) begin
            csOneHot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_bus_master.sv
// Single-outstanding peripheral bus initiator: accepts one core request,
// performs one registered bus access, and returns ack/read data.
module periph_bus_master
   import periph_bus_master_pkg::*;
#(
   parameter int NUM_PERIPH = 4,
   parameter int RD_WAIT    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   periph_bus_master_if.master  bus
);

   state_t                  state, stateNext;
   req_t                    reqLat, reqNext;
   logic [WAIT_W-1:0]       waitCnt, waitNext;

   logic [NUM_PERIPH-1:0]   csReg, csNext;
   logic                    rdReg, rdNext;
   logic                    wrReg, wrNext;
   logic [REG_ADDR_W-1:0]   addrReg, addrNext;
   logic [BUS_WDATA_W-1:0]  dInReg, dInNext;

   logic                    reqReadyReg, reqReadyNext;
   logic                    rspValidReg, rspValidNext;
   logic [BUS_RDATA_W-1:0]  rdataReg, rdataNext;
   logic                    errReg, errNext;

   logic [PERIPH_IDX_W-1:0] reqIdx;
   logic [NUM_PERIPH-1:0]   csDecoded;
   logic                    outOfRange;
   logic [BUS_RDATA_W-1:0]  slotData;

   assign reqIdx = periphIndex(bus.req_addr);

   periph_bus_master_cs_decode #(
      .NUM_PERIPH (NUM_PERIPH)
   ) uDecode (
      .index      (reqIdx),
      .csOneHot   (csDecoded),
      .outOfRange (outOfRange)
   );

   // Slot mux keyed on the latched index, which is always in range here.
   always_comb begin
      slotData = '0;
      for (int i = 0; i < NUM_PERIPH; i++) begin
         if (reqLat.idx == PERIPH_IDX_W'(i)) begin
            slotData = bus.d_out_bus[BUS_RDATA_W*i +: BUS_RDATA_W];
         end
      end
   end

   // Next-state logic; every bus and response output is computed one cycle
   // ahead so the registers below present glitch-free strobes.
   always_comb begin
      stateNext    = state;
      reqNext      = reqLat;
      waitNext     = waitCnt;
      csNext       = csReg;
      rdNext       = rdReg;
      wrNext       = wrReg;
      addrNext     = addrReg;
      dInNext      = dInReg;
      reqReadyNext = reqReadyReg;
      rspValidNext = rspValidReg;
      rdataNext    = rdataReg;
      errNext      = errReg;

      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               reqNext.we   = bus.req_we;
               reqNext.idx  = reqIdx;
               reqReadyNext = 1'b0;
               if (outOfRange) begin
                  stateNext    = RESP;
                  rspValidNext = 1'b1;
                  errNext      = 1'b1;
                  rdataNext    = '0;
               end else begin
                  stateNext = ACCESS;
                  csNext    = csDecoded;
                  rdNext    = !bus.req_we;
                  wrNext    = bus.req_we;
                  addrNext  = regAddress(bus.req_addr);
                  dInNext   = bus.req_wdata;
                  waitNext  = WAIT_W'(RD_WAIT);
                  errNext   = 1'b0;
               end
            end
         end

         ACCESS: begin
            if (reqLat.we || (waitCnt == '0)) begin
               stateNext    = RESP;
               csNext       = '0;
               rdNext       = 1'b0;
               wrNext       = 1'b0;
               rspValidNext = 1'b1;
               errNext      = 1'b0;
               rdataNext    = reqLat.we ? '0 : slotData;
            end else begin
               waitNext = waitCnt - WAIT_W'(1);
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               stateNext    = IDLE;
               rspValidNext = 1'b0;
               reqReadyNext = 1'b1;
            end
         end

         default: begin
            stateNext    = IDLE;
            csNext       = '0;
            rdNext       = 1'b0;
            wrNext       = 1'b0;
            rspValidNext = 1'b0;
            reqReadyNext = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         reqLat      <= '0;
         waitCnt     <= '0;
         csReg       <= '0;
         rdReg       <= 1'b0;
         wrReg       <= 1'b0;
         addrReg     <= '0;
         dInReg      <= '0;
         reqReadyReg <= 1'b1;
         rspValidReg <= 1'b0;
         rdataReg    <= '0;
         errReg      <= 1'b0;
      end else begin
         state       <= stateNext;
         reqLat      <= reqNext;
         waitCnt     <= waitNext;
         csReg       <= csNext;
         rdReg       <= rdNext;
         wrReg       <= wrNext;
         addrReg     <= addrNext;
         dInReg      <= dInNext;
         reqReadyReg <= reqReadyNext;
         rspValidReg <= rspValidNext;
         rdataReg    <= rdataNext;
         errReg      <= errNext;
      end
   end

   assign bus.req_ready = reqReadyReg;
   assign bus.rsp_valid = rspValidReg;
   assign bus.rsp_rdata = rdataReg;
   assign bus.rsp_err   = errReg;
   assign bus.cs        = csReg;
   assign bus.rd        = rdReg;
   assign bus.wr        = wrReg;
   assign bus.addr      = addrReg;
   assign bus.d_in      = dInReg;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master: one instance with RD_WAIT=0 and one
// with RD_WAIT=3, both with four peripheral slots.
module tb_periph_bus_master;
   import periph_bus_master_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   periph_bus_master_if #(.NUM_PERIPH(4)) busA ();
   periph_bus_master_if #(.NUM_PERIPH(4)) busB ();

   periph_bus_master #(.NUM_PERIPH(4), .RD_WAIT(0)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   periph_bus_master #(.NUM_PERIPH(4), .RD_WAIT(3)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit useB, input logic valid, input logic we,
                                input logic [7:0] reqAddr, input logic [15:0] wdata,
                                input logic rspReady);
      if (useB) begin
         busB.req_valid = valid;
         busB.req_we    = we;
         busB.req_addr  = reqAddr;
         busB.req_wdata = wdata;
         busB.rsp_ready = rspReady;
      end else begin
         busA.req_valid = valid;
         busA.req_we    = we;
         busA.req_addr  = reqAddr;
         busA.req_wdata = wdata;
         busA.rsp_ready = rspReady;
      end
   endtask

   initial begin
      reset          = 1'b0;
      busA.d_out_bus = '0;
      busB.d_out_bus = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      tick();
      tick();

      // Reset state
      checkOutput("rst_req_ready", 32'(busA.req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(busA.rsp_valid), 32'd0);
      checkOutput("rst_rdata",     busA.rsp_rdata,      32'd0);
      checkOutput("rst_err",       32'(busA.rsp_err),   32'd0);
      checkOutput("rst_cs",        32'(busA.cs),        32'd0);
      checkOutput("rst_rd_wr",     32'({busA.rd, busA.wr}), 32'd0);
      checkOutput("rst_addr",      32'(busA.addr),      32'd0);
      checkOutput("rst_d_in",      32'(busA.d_in),      32'd0);
      checkOutput("rstB_req_ready", 32'(busB.req_ready), 32'd1);
      checkOutput("rstB_cs",        32'(busB.cs),        32'd0);

      reset = 1'b1;
      tick();
      checkOutput("idle_req_ready", 32'(busA.req_ready), 32'd1);

      // Write 0x0503 to the multiplier slot, register 0
      applyStimulus(1'b0, 1'b1, 1'b1, {3'(PERIPH_MULT), 5'd0}, 16'h0503, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("wr_cs",        32'(busA.cs),        32'h2);
      checkOutput("wr_wr",        32'(busA.wr),        32'd1);
      checkOutput("wr_rd",        32'(busA.rd),        32'd0);
      checkOutput("wr_addr",      32'(busA.addr),      32'd0);
      checkOutput("wr_d_in",      32'(busA.d_in),      32'h0503);
      checkOutput("wr_req_ready", 32'(busA.req_ready), 32'd0);
      checkOutput("wr_rsp_valid", 32'(busA.rsp_valid), 32'd0);
      tick();
      checkOutput("wr_strobe_end", 32'({busA.cs, busA.wr}), 32'd0);
      checkOutput("wr_rsp_valid2", 32'(busA.rsp_valid), 32'd1);
      checkOutput("wr_rsp_rdata",  busA.rsp_rdata,      32'd0);
      checkOutput("wr_rsp_err",    32'(busA.rsp_err),   32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("wr_done_valid", 32'(busA.rsp_valid), 32'd0);
      checkOutput("wr_done_ready", 32'(busA.req_ready), 32'd1);

      // Read slot 1 register 2 with no wait states
      busA.d_out_bus[63:32] = 32'h0000_000F;
      busA.d_out_bus[95:64] = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 1'b1, 1'b0, {3'd1, 5'd2}, 16'h0000, 1'b0);
      tick();
      checkOutput("rd0_cs",   32'(busA.cs),   32'h2);
      checkOutput("rd0_rd",   32'(busA.rd),   32'd1);
      checkOutput("rd0_wr",   32'(busA.wr),   32'd0);
      checkOutput("rd0_addr", 32'(busA.addr), 32'd2);

      // A second request presented while busy must be held off
      applyStimulus(1'b0, 1'b1, 1'b1, {3'd1, 5'd9}, 16'h1234, 1'b0);
      tick();
      checkOutput("rd0_rd_end",   32'(busA.rd),        32'd0);
      checkOutput("rd0_rsp_valid", 32'(busA.rsp_valid), 32'd1);
      checkOutput("rd0_rdata",    busA.rsp_rdata,      32'h0000_000F);

      // Response held for five cycles with rsp_ready low
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("hold_rsp_valid", 32'(busA.rsp_valid), 32'd1);
         checkOutput("hold_rdata",     busA.rsp_rdata,      32'h0000_000F);
         checkOutput("hold_req_ready", 32'(busA.req_ready), 32'd0);
         checkOutput("hold_strobes",   32'({busA.cs, busA.rd, busA.wr}), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("hold_release_valid", 32'(busA.rsp_valid), 32'd0);
      checkOutput("hold_release_ready", 32'(busA.req_ready), 32'd1);
      checkOutput("hold_no_wr",         32'(busA.wr),        32'd0);

      // Out-of-range index 6 never touches the bus
      applyStimulus(1'b0, 1'b1, 1'b0, {3'd6, 5'd1}, 16'h0000, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("err_strobes",   32'({busA.cs, busA.rd, busA.wr}), 32'd0);
      checkOutput("err_rsp_valid", 32'(busA.rsp_valid), 32'd1);
      checkOutput("err_rsp_err",   32'(busA.rsp_err),   32'd1);
      checkOutput("err_rdata",     busA.rsp_rdata,      32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("err_done_ready", 32'(busA.req_ready), 32'd1);

      // Read slot 2 with three wait states; data changes during the third
      busB.d_out_bus[95:64] = 32'hAAAA_0000;
      applyStimulus(1'b1, 1'b1, 1'b0, {3'd2, 5'd7}, 16'h0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("rd3_cs",   32'(busB.cs),   32'h4);
      checkOutput("rd3_addr", 32'(busB.addr), 32'd7);
      checkOutput("rd3_rd_c1", 32'(busB.rd),  32'd1);
      tick();
      checkOutput("rd3_rd_c2", 32'(busB.rd),  32'd1);
      tick();
      checkOutput("rd3_rd_c3", 32'(busB.rd),  32'd1);
      busB.d_out_bus[95:64] = 32'h1234_5678;
      tick();
      checkOutput("rd3_rd_c4",  32'(busB.rd),        32'd1);
      checkOutput("rd3_no_rsp", 32'(busB.rsp_valid), 32'd0);
      tick();
      checkOutput("rd3_rd_end",    32'({busB.cs, busB.rd}), 32'd0);
      checkOutput("rd3_rsp_valid", 32'(busB.rsp_valid), 32'd1);
      checkOutput("rd3_rdata",     busB.rsp_rdata,      32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("rd3_done_ready", 32'(busB.req_ready), 32'd1);

      // Reset asserted in the middle of a read access
      busB.d_out_bus[127:96] = 32'hCAFE_F00D;
      applyStimulus(1'b1, 1'b1, 1'b0, {3'd3, 5'd4}, 16'h0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      checkOutput("mid_rd_active", 32'(busB.rd), 32'd1);
      checkOutput("mid_cs_active", 32'(busB.cs), 32'h8);
      reset = 1'b0;
      tick();
      checkOutput("mid_rst_cs",        32'(busB.cs),        32'd0);
      checkOutput("mid_rst_rd",        32'(busB.rd),        32'd0);
      checkOutput("mid_rst_rsp_valid", 32'(busB.rsp_valid), 32'd0);
      checkOutput("mid_rst_req_ready", 32'(busB.req_ready), 32'd1);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("mid_rsp_lost", 32'({busB.rsp_valid, busB.rd}), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
